// File: rtl/ps2_piano_key_scheduler_if.sv
// ps2_piano_key_scheduler_if: PS2 byte stream in, arbitrated piano note out
interface ps2_piano_key_scheduler_if;
  logic [7:0] received_data;
  logic       received_data_en;
  logic [7:0] held_keys;
  logic       note_valid;
  logic [2:0] note_index;
  logic       note_strobe;
  logic       seq_abort;
  modport master (
    output received_data, received_data_en,
    input  held_keys, note_valid, note_index, note_strobe, seq_abort
  );
  modport slave (
    input  received_data, received_data_en,
    output held_keys, note_valid, note_index, note_strobe, seq_abort
  );
endinterface

// File: rtl/ps2_piano_key_scheduler.sv
// ps2_piano_key_scheduler: decodes Set-2 make/break bytes into held piano keys and one active note
module ps2_piano_key_scheduler #(
  parameter int PREFIX_TIMEOUT = 1350000,
  parameter int TIMEOUT_W      = 21
) (
  input logic clk,
  input logic reset,
  ps2_piano_key_scheduler_if.slave bus
);
  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} state_t;
  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [7:0]           r_held;
  logic                 r_valid;
  logic [2:0]           r_idx;
  logic                 r_strobe;
  logic                 r_abort;
  logic                 w_hit;
  logic [2:0]           w_key;
  logic                 w_en;
  logic [7:0]           w_d;
  logic                 w_press;
  logic                 w_release;
  logic                 w_timeout;
  logic [7:0]           w_held;
  logic                 w_valid;
  logic [2:0]           w_idx;
  assign w_en      = bus.received_data_en;
  assign w_d       = bus.received_data;
  assign w_press   = w_en && r_state == ST_IDLE && w_hit;
  assign w_release = w_en && r_state == ST_BRK && w_hit;
  assign w_timeout = r_state != ST_IDLE && !w_en && r_cnt == TIMEOUT_W'(PREFIX_TIMEOUT - 1);
  // map a scan code onto one of the eight C-scale keys
  always_comb begin
    w_hit = 1'b1;
    w_key = 3'd0;
    case (w_d)
      8'h1C: w_key = 3'd0;
      8'h1B: w_key = 3'd1;
      8'h23: w_key = 3'd2;
      8'h2B: w_key = 3'd3;
      8'h34: w_key = 3'd4;
      8'h33: w_key = 3'd5;
      8'h3B: w_key = 3'd6;
      8'h42: w_key = 3'd7;
      default: w_hit = 1'b0;
    endcase
  end
  // next held set and active note: newest press wins, release of the active note falls back to the lowest held key
  always_comb begin
    w_held  = r_held;
    w_valid = r_valid;
    w_idx   = r_idx;
    if (w_press && !r_held[w_key]) begin
      w_held[w_key] = 1'b1;
      w_valid       = 1'b1;
      w_idx         = w_key;
    end
    if (w_release && r_held[w_key]) begin
      w_held[w_key] = 1'b0;
      if (r_idx == w_key) begin
        w_valid = |w_held;
        w_idx   = 3'd0;
        for (int i = 7; i >= 0; i--) if (w_held[i]) w_idx = 3'(i);
      end
    end
  end
  // parser state, prefix timeout and registered note outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_held   <= '0;
      r_valid  <= 1'b0;
      r_idx    <= 3'd0;
      r_strobe <= 1'b0;
      r_abort  <= 1'b0;
    end else begin
      r_held   <= w_held;
      r_valid  <= w_valid;
      r_idx    <= w_idx;
      r_strobe <= {w_valid, w_idx} != {r_valid, r_idx};
      r_abort  <= w_timeout;
      if (w_en) begin
        r_cnt <= '0;
        case (r_state)
          ST_IDLE:    r_state <= w_d == 8'hF0 ? ST_BRK : w_d == 8'hE0 ? ST_EXT : ST_IDLE;
          ST_EXT:     r_state <= w_d == 8'hF0 ? ST_EXT_BRK : w_d == 8'hE0 ? ST_EXT : ST_IDLE;
          ST_BRK:     r_state <= (w_d == 8'hF0 || w_d == 8'hE0) ? ST_BRK : ST_IDLE;
          default:    r_state <= ST_IDLE;
        endcase
      end else if (w_timeout) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else if (r_state != ST_IDLE) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
  assign bus.held_keys   = r_held;
  assign bus.note_valid  = r_valid;
  assign bus.note_index  = r_idx;
  assign bus.note_strobe = r_strobe;
  assign bus.seq_abort   = r_abort;
endmodule

// File: tb/tb_ps2_piano_key_scheduler.sv
// tb_ps2_piano_key_scheduler: directed scenarios plus random byte stream against a behavioural key model
module tb_ps2_piano_key_scheduler;
  localparam int T = 16;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int n_strobe = 0;
  int n_abort = 0;
  ps2_piano_key_scheduler_if bus();
  ps2_piano_key_scheduler #(.PREFIX_TIMEOUT(T), .TIMEOUT_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] codes [8] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42};
  bit m_held [8];
  int m_active;
  bit m_ext, m_brk;
  int m_idle;
  bit m_strobe, m_abort;
  function automatic int key_of(logic [7:0] d);
    for (int k = 0; k < 8; k++) if (codes[k] == d) return k;
    return -1;
  endfunction
  function automatic logic [7:0] held_vec();
    logic [7:0] v;
    for (int k = 0; k < 8; k++) v[k] = m_held[k];
    return v;
  endfunction
  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 8; k++) m_held[k] = 0;
      m_active = -1; m_ext = 0; m_brk = 0; m_idle = 0; m_strobe = 0; m_abort = 0;
    end else begin
      automatic int old = m_active;
      automatic int k = key_of(bus.received_data);
      m_abort = 0;
      if (bus.received_data_en) begin
        automatic logic [7:0] d = bus.received_data;
        m_idle = 0;
        if (!m_ext && !m_brk) begin
          if (d == 8'hF0) m_brk = 1;
          else if (d == 8'hE0) m_ext = 1;
          else if (k >= 0 && !m_held[k]) begin m_held[k] = 1; m_active = k; end
        end else if (m_ext && !m_brk) begin
          if (d == 8'hF0) m_brk = 1;
          else if (d != 8'hE0) m_ext = 0;
        end else if (m_brk && !m_ext) begin
          if (d != 8'hF0 && d != 8'hE0) begin
            m_brk = 0;
            if (k >= 0 && m_held[k]) begin
              m_held[k] = 0;
              if (m_active == k) begin
                m_active = -1;
                for (int j = 7; j >= 0; j--) if (m_held[j]) m_active = j;
              end
            end
          end
        end else begin
          m_ext = 0; m_brk = 0;
        end
      end else if (m_ext || m_brk) begin
        m_idle++;
        if (m_idle == T) begin m_ext = 0; m_brk = 0; m_idle = 0; m_abort = 1; end
      end
      m_strobe = m_active != old;
    end
  end
  always @(negedge clk) begin
    chk("held_keys", bus.held_keys, held_vec());
    chk("note_valid", bus.note_valid, m_active >= 0);
    if (bus.note_valid && m_active >= 0) chk("note_index", bus.note_index, m_active);
    chk("note_strobe", bus.note_strobe, m_strobe);
    chk("seq_abort", bus.seq_abort, m_abort);
    n_strobe += bus.note_strobe;
    n_abort += bus.seq_abort;
  end
  task automatic tick(logic en, logic [7:0] d);
    @(posedge clk); #2;
    bus.received_data_en = en;
    bus.received_data = d;
  endtask
  task automatic send(logic [7:0] d);
    tick(1'b1, d);
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask
  task automatic do_reset();
    @(posedge clk); #2; reset = 1'b0;
    idle(2);
    @(posedge clk); #2; reset = 1'b1;
    idle(1);
    n_strobe = 0;
    n_abort = 0;
  endtask
  initial begin
    bus.received_data_en = 1'b0;
    bus.received_data = 8'h00;
    idle(3);
    chk("reset_held", bus.held_keys, 0);
    chk("reset_valid", bus.note_valid, 0);
    chk("reset_index", bus.note_index, 0);
    reset = 1'b1;
    idle(2);
    send(8'hF0);
    do_reset();
    send(8'h1C); idle(2);
    chk("t1_held", bus.held_keys, 8'h01);
    chk("t1_valid", bus.note_valid, 1);
    chk("t1_index", bus.note_index, 0);
    chk("t1_strobes", n_strobe, 1);
    do_reset();
    send(8'h1C); send(8'h23); idle(2);
    chk("t2_held_a", bus.held_keys, 8'h05);
    chk("t2_index_a", bus.note_index, 2);
    send(8'hF0); send(8'h23); idle(2);
    chk("t2_held_b", bus.held_keys, 8'h01);
    chk("t2_index_b", bus.note_index, 0);
    chk("t2_strobes", n_strobe, 3);
    do_reset();
    repeat (4) send(8'h34);
    idle(2);
    chk("t3_held", bus.held_keys, 8'h10);
    chk("t3_index", bus.note_index, 4);
    chk("t3_strobes", n_strobe, 1);
    do_reset();
    send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C); idle(2);
    chk("t4_held", bus.held_keys, 0);
    chk("t4_valid", bus.note_valid, 0);
    chk("t4_strobes", n_strobe, 0);
    do_reset();
    send(8'hF0); idle(T); send(8'h1C); idle(2);
    chk("t5_aborts", n_abort, 1);
    chk("t5_held", bus.held_keys, 8'h01);
    send(8'hF0); idle(T - 1); send(8'h1C); idle(2);
    chk("t5_byte_wins_aborts", n_abort, 1);
    chk("t5_byte_wins_held", bus.held_keys, 8'h00);
    do_reset();
    send(8'h1C); send(8'h2B); send(8'h42); idle(2);
    chk("t6_index_a", bus.note_index, 7);
    send(8'hF0); send(8'h42); idle(2);
    chk("t6_index_b", bus.note_index, 0);
    send(8'hF0); send(8'h1C); idle(2);
    chk("t6_index_c", bus.note_index, 3);
    send(8'hF0); send(8'h2B); idle(2);
    chk("t6_valid", bus.note_valid, 0);
    chk("t6_strobes", n_strobe, 6);
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      automatic int r = $urandom_range(0, 99);
      if (r < 30) send(codes[$urandom_range(0, 7)]);
      else if (r < 45) send(8'hF0);
      else if (r < 52) send(8'hE0);
      else if (r < 57) send(8'($urandom));
      else if (r < 59) idle($urandom_range(T - 2, T + 2));
      else if (r < 60) begin
        @(posedge clk); #2; reset = 1'b0;
        @(posedge clk); #2; reset = 1'b1;
      end
      else idle(1);
    end
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ps2_piano_key_scheduler.md
Name: ps2_piano_key_scheduler

Overview:
- Consumes the byte stream from the PS2 receiver (received_data / received_data_en) and decodes Set-2 make/break sequences (F0 break prefix, E0 extended prefix).
- Tracks press/release state of the eight C-scale piano keys.
- Arbitrates the held keys down to a single active note for the tone generator.
- Sits between the PS2 input core and the audio note generator. Replaces the timeout-based release approximation with true break-code release handling.

Parameters:
- PREFIX_TIMEOUT, 1350000: idle cycles after a prefix byte before the parser abandons the sequence (50 ms at 27 MHz).
- TIMEOUT_W, 21: width of the prefix timeout counter; must hold PREFIX_TIMEOUT.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- received_data  input  8  byte from the PS2 receiver; valid only when received_data_en=1.
- received_data_en  input  1  single-cycle strobe, new byte available.
- held_keys  output  8  bit i=1 while piano key i is held. Mapping: 0=C(1C) 1=D(1B) 2=E(23) 3=F(2B) 4=G(34) 5=A(33) 6=B(3B) 7=C'(42).
- note_valid  output  1  at least one key is held.
- note_index  output  3  active key index; meaningful only when note_valid=1.
- note_strobe  output  1  one-cycle pulse when {note_valid, note_index} changes.
- seq_abort  output  1  one-cycle pulse when a prefix sequence times out.

Behaviour:
- Reset (reset=0, asynchronous):
  - Parser goes to ST_IDLE.
  - held_keys=0, note_valid=0, note_index=0, note_strobe=0, seq_abort=0.
  - Timeout counter cleared.
- Bytes are processed only on a clk edge where received_data_en=1. All register updates from a byte occur on that edge (latency 1 cycle from strobe to outputs).
- Parser FSM transitions:
  - ST_IDLE:
    - F0 -> ST_BRK.
    - E0 -> ST_EXT.
    - Mapped code -> press that key, stay ST_IDLE.
    - Any other byte -> ignored, stay ST_IDLE.
  - ST_EXT:
    - F0 -> ST_EXT_BRK.
    - E0 -> stay ST_EXT.
    - Other byte -> discarded (extended make), -> ST_IDLE.
  - ST_BRK:
    - E0/F0 -> stay ST_BRK (malformed; the prefix is kept).
    - Mapped code -> release that key, -> ST_IDLE.
    - Other byte -> -> ST_IDLE.
  - ST_EXT_BRK: any byte -> discarded, -> ST_IDLE.
- Extended (E0-prefixed) codes never affect held_keys, even if the low byte matches a piano code.
- Timeout:
  - Counter clears on every accepted byte and counts while the parser is in a prefix state (not ST_IDLE).
  - On reaching PREFIX_TIMEOUT-1 with no byte that cycle: parser -> ST_IDLE, seq_abort pulses for 1 cycle, counter clears.
  - If a byte arrives on the same edge the timeout would fire, the byte wins and seq_abort stays 0.
- Press of a key:
  - Sets its held bit.
  - If the key was not already held, it becomes the active note (most recent press wins).
  - A typematic repeat of an already-held key changes nothing and produces no strobe.
- Release of a key:
  - Clears its held bit.
  - If it was the active note, the active note falls back to the lowest-index key still held, or note_valid=0 if none remain.
  - Release of a key not held changes nothing.
- note_strobe is registered. It is 1 in the cycle after the edge where {note_valid, note_index} changed, else 0.
- No other inputs gate operation; every accepted byte is consumed, with no backpressure.

Test Plan:
1. Reset low mid-sequence (after F0), then release; send 1C -> parser in ST_IDLE, held_keys=00000001, note_valid=1, note_index=0, one note_strobe pulse.
2. Send 1C, 23, then F0 23 -> after 23: note_index=2, held_keys=05; after F0 23: held_keys=01, note_index=0, note_strobe pulses exactly 3 times total.
3. Send 34 four times (typematic) -> held_keys=10, note_index=4, exactly 1 note_strobe pulse.
4. Send E0 1C, then E0 F0 1C -> held_keys stays 00, note_valid=0, no note_strobe.
5. With PREFIX_TIMEOUT=16: send F0, wait 16 idle cycles, send 1C -> seq_abort pulses once; 1C treated as a press (held_keys=01), not a release.
6. Hold 1C, 2B, 42 (active=7), release 42 then 1C -> active becomes 0 (lowest held), then 3; release 2B -> note_valid=0 with a strobe.
